// File: rtl/i2s_sample_tx_pkg.sv
// Shared types and default geometry for the I2S sample transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package i2s_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } i2s_state_e;

   localparam int unsigned WIDTH_DEF      = 12;
   localparam int unsigned SLOT_WIDTH_DEF = 16;
   localparam int unsigned SCLK_DIV_DEF   = 2;

   // Counter width for a modulus, never narrower than one bit.
   function automatic int unsigned cnt_w(input int unsigned modulus);
      return (modulus > 1) ? $clog2(modulus) : 1;
   endfunction

endpackage

// File: rtl/i2s_sample_tx_sclk_gen.sv
// Bit-clock generator: divides clk into sclk and flags the falling edge.
// Latency: first sclk rise sclk_div_p cycles after run_i goes high.
// Backpressure: none; held low and re-phased whenever run_i is low.
module sclk_gen
   import i2s_pkg::*;
#(
   parameter int unsigned sclk_div_p = SCLK_DIV_DEF
) (
   input  logic clk_i,
   input  logic reset_ni,
   input  logic run_i,
   output logic sclk_o,
   output logic fall_o
);

   logic div_wrap;
   logic sclk_r;

   wave_counter #(
      .max_p (sclk_div_p)
   ) u_div (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .en_i     (run_i),
      .clr_i    (!run_i),
      .wrap_o   (div_wrap)
   );

   // fall_o marks the cycle whose posedge drives sclk 1->0.
   assign fall_o = div_wrap & sclk_r;
   assign sclk_o = sclk_r;

   // Toggle sclk on each divider wrap; starting low makes the first edge rising.
   always_ff @(posedge clk_i) begin
      if (!reset_ni || !run_i) begin
         sclk_r <= 1'b0;
      end else if (div_wrap) begin
         sclk_r <= ~sclk_r;
      end
   end

endmodule

// File: rtl/wave_counter.sv
// Free-running modulo counter that pulses wrap on its terminal count.
// Latency: wrap is combinational from the count register.
// Backpressure: none; counts only while enabled, clear wins over enable.
module wave_counter
   import i2s_pkg::*;
#(
   parameter int unsigned max_p = 2
) (
   input  logic clk_i,
   input  logic reset_ni,
   input  logic en_i,
   input  logic clr_i,
   output logic wrap_o
);

   localparam int unsigned cnt_w_lp = cnt_w(max_p);

   logic [cnt_w_lp-1:0] cnt_r;

   assign wrap_o = en_i && (cnt_r == cnt_w_lp'(max_p - 1));

   // Count 0..max_p-1 while enabled, restart from 0 on clear or reset.
   always_ff @(posedge clk_i) begin
      if (!reset_ni || clr_i) begin
         cnt_r <= '0;
      end else if (en_i) begin
         cnt_r <= wrap_o ? '0 : cnt_r + 1'b1;
      end
   end

endmodule

// File: rtl/i2s_sample_tx.sv
// I2S transmitter: one-entry sample buffer feeding a mono (L=R) serializer.
// Latency: frame starts the cycle after the first accepted sample; MSB one sclk later.
// Backpressure: ready_o low while the buffer holds a sample not yet loaded into a frame.
module i2s_sample_tx
   import i2s_pkg::*;
#(
   parameter int unsigned width_p      = WIDTH_DEF,
   parameter int unsigned slot_width_p = SLOT_WIDTH_DEF,
   parameter int unsigned sclk_div_p   = SCLK_DIV_DEF
) (
   input  logic               clk_i,
   input  logic               reset_ni,
   input  logic [width_p-1:0] data_i,
   input  logic               valid_i,
   output logic               ready_o,
   output logic               sclk_o,
   output logic               lrclk_o,
   output logic               sdata_o,
   output logic               underrun_o
);

   localparam int unsigned frame_lp = 2 * slot_width_p;
   localparam int unsigned bit_w_lp = cnt_w(frame_lp);
   localparam int unsigned pad_lp   = slot_width_p - width_p;

   i2s_state_e state_r, state_n;

   logic                    rdy_en_r;
   logic                    buf_full_r;
   logic [width_p-1:0]      buf_dat_r;
   logic [width_p-1:0]      cur_r;
   logic [slot_width_p-1:0] shift_r;
   logic [bit_w_lp-1:0]     bit_cnt_r;
   logic [bit_w_lp-1:0]     bit_cnt_nxt;
   logic                    lrclk_r;
   logic                    sdata_r;
   logic                    underrun_r;

   logic                    run;
   logic                    enter;
   logic                    fall;
   logic                    last_bit;
   logic                    mid_bit;
   logic                    frame_start;
   logic                    right_start;
   logic                    accept;
   logic                    load_buf;
   logic [slot_width_p-1:0] img_buf;
   logic [slot_width_p-1:0] img_cur;

   sclk_gen #(
      .sclk_div_p (sclk_div_p)
   ) u_sclk (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .run_i    (run),
      .sclk_o   (sclk_o),
      .fall_o   (fall)
   );

   // Slot images: sample in the MSBs, zero-padded LSBs (no sign extension).
   assign img_buf = slot_width_p'(buf_dat_r) << pad_lp;
   assign img_cur = slot_width_p'(cur_r) << pad_lp;

   assign last_bit    = (bit_cnt_r == bit_w_lp'(frame_lp - 1));
   assign mid_bit     = (bit_cnt_r == bit_w_lp'(slot_width_p - 1));
   assign bit_cnt_nxt = last_bit ? '0 : bit_cnt_r + 1'b1;
   assign frame_start = fall & last_bit;
   assign right_start = fall & mid_bit;

   assign ready_o  = rdy_en_r & ~buf_full_r;
   assign accept   = valid_i & ready_o;
   assign load_buf = enter | (frame_start & buf_full_r);

   assign lrclk_o    = lrclk_r;
   assign sdata_o    = sdata_r;
   assign underrun_o = underrun_r;

   // FSM state register.
   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_n;
      end
   end

   // FSM next state: leave IDLE once a sample is buffered, then stay in RUN.
   always_comb begin
      state_n = state_r;
      case (state_r)
         IDLE:    if (buf_full_r) state_n = RUN;
         RUN:     state_n = RUN;
         default: state_n = IDLE;
      endcase
   end

   // FSM outputs: run enables the bit clock, enter loads the first frame.
   always_comb begin
      run   = 1'b0;
      enter = 1'b0;
      case (state_r)
         IDLE:    enter = buf_full_r;
         RUN:     run   = 1'b1;
         default: ;
      endcase
   end

   // One-entry buffer; an accept takes priority over the clear from a frame load.
   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         rdy_en_r   <= 1'b0;
         buf_full_r <= 1'b0;
         buf_dat_r  <= '0;
      end else begin
         rdy_en_r <= 1'b1;
         if (accept) begin
            buf_full_r <= 1'b1;
            buf_dat_r  <= data_i;
         end else if (load_buf) begin
            buf_full_r <= 1'b0;
         end
      end
   end

   // Frame sequencing: bit counter, word select, shift register and held sample.
   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         cur_r     <= '0;
         shift_r   <= '0;
         bit_cnt_r <= '0;
         lrclk_r   <= 1'b0;
         sdata_r   <= 1'b0;
      end else if (enter) begin
         cur_r     <= buf_dat_r;
         shift_r   <= img_buf;
         bit_cnt_r <= '0;
         lrclk_r   <= 1'b0;
         sdata_r   <= 1'b0;
      end else if (fall) begin
         bit_cnt_r <= bit_cnt_nxt;
         lrclk_r   <= (bit_cnt_nxt >= bit_w_lp'(slot_width_p));
         // The bit leaving now is the previous slot's LSB at a slot boundary,
         // which produces the one-sclk data delay after the word-select change.
         sdata_r   <= shift_r[slot_width_p-1];
         if (frame_start) begin
            if (buf_full_r) begin
               cur_r   <= buf_dat_r;
               shift_r <= img_buf;
            end else begin
               shift_r <= img_cur;
            end
         end else if (right_start) begin
            shift_r <= img_cur;
         end else begin
            shift_r <= shift_r << 1;
         end
      end
   end

   // Underrun flag: one cycle when a frame starts with nothing buffered.
   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         underrun_r <= 1'b0;
      end else begin
         underrun_r <= frame_start & ~buf_full_r;
      end
   end

endmodule

// File: tb/tb_i2s_sample_tx.sv
// Directed bench for i2s_sample_tx: decodes the I2S stream like a DAC would.
// Latency: n/a.
// Backpressure: valid/ready handshakes driven from the main sequence.
module tb_i2s_sample_tx;

   logic        clk = 1'b0;
   logic        reset_ni;
   logic [11:0] data_i;
   logic        valid_i;
   logic        ready_o;
   logic        sclk_o;
   logic        lrclk_o;
   logic        sdata_o;
   logic        underrun_o;

   int cmp_cnt = 0;
   int err_cnt = 0;

   always #5 clk = ~clk;

   i2s_sample_tx #(
      .width_p      (12),
      .slot_width_p (16),
      .sclk_div_p   (2)
   ) dut (
      .clk_i      (clk),
      .reset_ni   (reset_ni),
      .data_i     (data_i),
      .valid_i    (valid_i),
      .ready_o    (ready_o),
      .sclk_o     (sclk_o),
      .lrclk_o    (lrclk_o),
      .sdata_o    (sdata_o),
      .underrun_o (underrun_o)
   );

   // ---------------- monitor / I2S decoder (negedge sampling) ----------------
   logic [16:0] words[$];
   int          acc_t[$];
   int          cyc = 0;
   int          ur_pulses, ur_cycles, per_min, per_max, viol;
   logic        p_sclk, p_lr, p_sd, p_ur, have_prev;
   logic        dec_lr, dec_have;
   logic [15:0] dec_sh;
   int          dec_nb, last_rise;
   logic        have_rise;

   always @(negedge clk) begin
      cyc++;
      if (!reset_ni) begin
         words.delete();
         acc_t.delete();
         ur_pulses = 0; ur_cycles = 0; viol = 0;
         per_min = 1000; per_max = 0;
         have_prev = 1'b0; have_rise = 1'b0; dec_have = 1'b0;
         dec_nb = 0; dec_sh = '0; p_ur = 1'b0;
      end else begin
         if (valid_i && ready_o) acc_t.push_back(cyc);
         if (underrun_o) begin
            ur_cycles++;
            if (!p_ur) ur_pulses++;
         end
         if (have_prev && (lrclk_o !== p_lr || sdata_o !== p_sd) && !(p_sclk && !sclk_o))
            viol++;
         if (have_prev && !p_sclk && sclk_o) begin
            if (have_rise) begin
               if (cyc - last_rise < per_min) per_min = cyc - last_rise;
               if (cyc - last_rise > per_max) per_max = cyc - last_rise;
            end
            last_rise = cyc;
            have_rise = 1'b1;
            // Bit at this rise belongs to the slot selected at the previous rise.
            if (dec_have) begin
               dec_sh = {dec_sh[14:0], sdata_o};
               dec_nb++;
               if (dec_nb == 16) begin
                  words.push_back({dec_lr, dec_sh});
                  dec_nb = 0;
               end
            end
            dec_lr   = lrclk_o;
            dec_have = 1'b1;
         end
         p_sclk = sclk_o; p_lr = lrclk_o; p_sd = sdata_o; p_ur = underrun_o;
         have_prev = 1'b1;
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      cmp_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      reset_ni = 1'b0;
      valid_i  = 1'b0;
      repeat (n) tick();
      reset_ni = 1'b1;
      tick();
   endtask

   // Offer one sample; returns on the tick after the accepting edge.
   task automatic send(input logic [11:0] d, input bit keep_valid);
      logic rb;
      int   k = 0;
      data_i  = d;
      valid_i = 1'b1;
      do begin
         rb = ready_o;
         tick();
         k++;
      end while (!rb && k < 400);
      if (!rb) chk("send_timeout", 32'(k), 32'd0);
      if (!keep_valid) valid_i = 1'b0;
   endtask

   task automatic wait_words(input int n, input int budget);
      int k = 0;
      while (words.size() < n && k < budget) begin
         tick();
         k++;
      end
      chk("word_count", 32'(words.size() >= n), 32'd1);
   endtask

   task automatic chk_word(input int j, input logic [11:0] s);
      logic [16:0] w;
      if (j < words.size()) w = words[j];
      else                  w = 'x;
      chk($sformatf("word%0d", j), 32'(w), 32'({j[0], s, 4'h0}));
   endtask

   logic [11:0] saw[7];

   // ---------------- main sequence ----------------
   initial begin
      // Reset with valid held: everything stays low, nothing is accepted.
      reset_ni = 1'b0;
      valid_i  = 1'b1;
      data_i   = 12'h7FF;
      repeat (5) tick();
      chk("rst_ready",    32'(ready_o),    32'd0);
      chk("rst_sclk",     32'(sclk_o),     32'd0);
      chk("rst_lrclk",    32'(lrclk_o),    32'd0);
      chk("rst_sdata",    32'(sdata_o),    32'd0);
      chk("rst_underrun", 32'(underrun_o), 32'd0);
      reset_ni = 1'b1;
      valid_i  = 1'b0;
      tick();
      chk("rel_ready", 32'(ready_o), 32'd1);
      chk("idle_sclk", 32'(sclk_o),  32'd0);

      // Single sample then starvation: 4 frames of A5C0, 3 underrun pulses.
      send(12'hA5C, 1'b0);
      begin
         int k = 0;
         while (ur_pulses < 3 && k < 700) begin
            tick();
            k++;
         end
      end
      repeat (100) tick();
      chk("starve_words", 32'(words.size()), 32'd7);
      for (int j = 0; j < 7; j++) chk_word(j, 12'hA5C);
      chk("starve_ur_pulses", 32'(ur_pulses), 32'd3);
      chk("starve_ur_cycles", 32'(ur_cycles), 32'd3);
      chk("sclk_period_min",  32'(per_min),   32'd4);
      chk("sclk_period_max",  32'(per_max),   32'd4);
      chk("edge_alignment",   32'(viol),      32'd0);
      chk("starve_accepts",   32'(acc_t.size()), 32'd1);

      // Continuous sawtooth stream: one accept per frame, order preserved.
      do_reset(3);
      for (int i = 0; i < 7; i++) saw[i] = 12'(12'h800 + i * 12'h29B);
      for (int i = 0; i < 7; i++) send(saw[i], 1'b1);
      valid_i = 1'b0;
      wait_words(10, 400);
      for (int j = 0; j < 10; j++) chk_word(j, saw[j/2]);
      chk("stream_accepts", 32'(acc_t.size()), 32'd7);
      if (acc_t.size() == 7) begin
         chk("stream_gap1", 32'(acc_t[1] - acc_t[0]), 32'd2);
         for (int i = 2; i < 7; i++)
            chk($sformatf("stream_gap%0d", i), 32'(acc_t[i] - acc_t[i-1]), 32'd128);
      end
      chk("stream_underrun", 32'(ur_pulses), 32'd0);

      // Backpressure: data changes while full are ignored.
      do_reset(3);
      send(12'h111, 1'b1);
      send(12'h222, 1'b1);
      data_i = 12'h3C3;
      chk("bp_ready_low", 32'(ready_o), 32'd0);
      begin
         int k = 0;
         while (!ready_o && k < 300) begin
            data_i = (k % 2 == 0) ? 12'hC3C : 12'h3C3;
            tick();
            k++;
         end
      end
      data_i = 12'h5A5;
      tick();
      valid_i = 1'b0;
      wait_words(6, 400);
      chk_word(0, 12'h111); chk_word(1, 12'h111);
      chk_word(2, 12'h222); chk_word(3, 12'h222);
      chk_word(4, 12'h5A5); chk_word(5, 12'h5A5);
      chk("bp_accepts", 32'(acc_t.size()), 32'd3);

      // Reset in the right slot, then restart cleanly.
      begin
         int k = 0;
         while (!lrclk_o && k < 200) begin
            tick();
            k++;
         end
         chk("midrst_in_right", 32'(lrclk_o), 32'd1);
      end
      repeat (5) tick();
      reset_ni = 1'b0;
      tick();
      chk("midrst_sclk",     32'(sclk_o),     32'd0);
      chk("midrst_lrclk",    32'(lrclk_o),    32'd0);
      chk("midrst_sdata",    32'(sdata_o),    32'd0);
      chk("midrst_underrun", 32'(underrun_o), 32'd0);
      chk("midrst_ready",    32'(ready_o),    32'd0);
      tick();
      reset_ni = 1'b1;
      tick();
      send(12'h0F0, 1'b0);
      tick();
      chk("restart_lrclk", 32'(lrclk_o), 32'd0);
      chk("restart_sclk0", 32'(sclk_o),  32'd0);
      tick();
      tick();
      chk("restart_sclk_rise", 32'(sclk_o),  32'd1);
      chk("restart_lrclk_hold", 32'(lrclk_o), 32'd0);
      wait_words(2, 200);
      chk_word(0, 12'h0F0);
      chk_word(1, 12'h0F0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
